bytewrite_ram_2p: RTL and testbench

//  Dual-port testbench memory with byte-wide write enables: port A is read-only (instruction fetch),

---
 rtl/rvj1_mem_pkg.sv | 19 +
 rtl/bytewrite_ram_resp_pipe.sv | 46 ++++
 rtl/bytewrite_ram_2p.sv | 116 +++++++++++
 tb/tb_bytewrite_ram_2p.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvj1_mem_pkg.sv
// Shared constants, helpers and response type for the testbench memory models.
package rvj1_mem_pkg;
    localparam int MAX_READ_LATENCY = 4;
    // Fibonacci taps 16,14,13,11 as a mask over lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int MEM_WORD = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    typedef struct packed {
        logic                err;
        logic [MEM_WORD-1:0] data;
    } mem_resp_t;
endpackage

// File: rtl/bytewrite_ram_resp_pipe.sv
// Fixed-latency response pipe: valid/err/data shift register, flushed by rst.
module bytewrite_ram_resp_pipe
    import rvj1_mem_pkg::*;
#(
    parameter int  READ_LATENCY = 1,
    parameter type resp_t       = mem_resp_t
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  in_vld,
    input  resp_t in_resp,
    output logic  out_vld,
    output resp_t out_resp
);
    localparam int L = (READ_LATENCY < 1) ? 1 :
                       (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;

    logic  vld_pipe  [1:L];
    resp_t resp_pipe [1:L];

    for (genvar k = 1; k <= L; k++) begin : g_stage
        logic  pv;
        resp_t pr;
        if (k == 1) begin : g_head
            assign pv = in_vld;
            assign pr = in_resp;
        end else begin : g_body
            assign pv = vld_pipe[k-1];
            assign pr = resp_pipe[k-1];
        end

        // The last stage only loads on a valid response so rdata holds between responses.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_pipe[k]  <= 1'b0;
                resp_pipe[k] <= '0;
            end else begin
                vld_pipe[k] <= pv;
                if (k < L || pv) resp_pipe[k] <= pr;
            end
        end
    end

    assign out_vld  = vld_pipe[L];
    assign out_resp = resp_pipe[L];
endmodule

// File: rtl/bytewrite_ram_2p.sv
// Dual-port byte-write memory (A read-only, B read/write) with req/gnt/rvalid handshakes.
// Define BYTEWRITE_RAM_STALL_EN for LFSR-driven random grant stalls.
module bytewrite_ram_2p
    import rvj1_mem_pkg::*;
#(
    parameter int                    SIZE         = 1024,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    COL_WIDTH    = 8,
    parameter int                    NB_COL       = 4,
    parameter int                    READ_LATENCY = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter logic [15:0]           LFSR_SEED    = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        a_req,
    input  logic [ADDR_WIDTH-1:0]       a_addr,
    output logic                        a_gnt,
    output logic                        a_rvalid,
    output logic [NB_COL*COL_WIDTH-1:0] a_rdata,
    output logic                        a_err,
    input  logic                        b_req,
    input  logic [NB_COL-1:0]           b_we,
    input  logic [ADDR_WIDTH-1:0]       b_addr,
    input  logic [NB_COL*COL_WIDTH-1:0] b_wdata,
    output logic                        b_gnt,
    output logic                        b_rvalid,
    output logic [NB_COL*COL_WIDTH-1:0] b_rdata,
    output logic                        b_err
);
    localparam int WORD = NB_COL * COL_WIDTH;
    localparam int OFF  = clog2(NB_COL);   // NB_COL >= 2 assumed
    localparam int IDXW = clog2(SIZE);

    // Same layout as mem_resp_t, sized to this instance's word.
    typedef struct packed {
        logic            err;
        logic [WORD-1:0] data;
    } resp_t;

    logic [WORD-1:0] mem [SIZE];

    function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word;
        word = (addr - BASE_ADDR) >> OFF;
        return (addr[OFF-1:0] != '0) || (addr < BASE_ADDR) || (word >= ADDR_WIDTH'(SIZE));
    endfunction

    function automatic logic [IDXW-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word;
        word = (addr - BASE_ADDR) >> OFF;
        return word[IDXW-1:0];
    endfunction

`ifdef BYTEWRITE_RAM_STALL_EN
    logic [15:0] a_lfsr, b_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_lfsr <= LFSR_SEED;
            b_lfsr <= ~LFSR_SEED;
        end else begin
            a_lfsr <= {a_lfsr[14:0], ^(a_lfsr & LFSR_TAPS)};
            b_lfsr <= {b_lfsr[14:0], ^(b_lfsr & LFSR_TAPS)};
        end
    end

    assign a_gnt = !rst && (a_lfsr[1:0] != 2'b00);
    assign b_gnt = !rst && (b_lfsr[1:0] != 2'b00);
`else
    assign a_gnt = !rst;
    assign b_gnt = !rst;
`endif

    logic            a_acc, b_acc, a_bad, b_bad;
    logic [IDXW-1:0] a_idx, b_idx;
    resp_t           a_in, b_in, a_out, b_out;

    assign a_acc = a_req && a_gnt;
    assign b_acc = b_req && b_gnt;
    assign a_bad = addr_bad(a_addr);
    assign b_bad = addr_bad(b_addr);
    assign a_idx = addr_idx(a_addr);
    assign b_idx = addr_idx(b_addr);

    // Responses sample the array before this edge's write: read-first on both ports.
    always_comb begin
        a_in     = '0;
        b_in     = '0;
        a_in.err = a_bad;
        b_in.err = b_bad;
        if (!a_bad) a_in.data = mem[a_idx];
        if (!b_bad) b_in.data = mem[b_idx];
    end

    always_ff @(posedge clk) begin
        if (b_acc && !b_bad) begin
            for (int i = 0; i < NB_COL; i++) begin
                if (b_we[i]) mem[b_idx][i*COL_WIDTH +: COL_WIDTH] <= b_wdata[i*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

    bytewrite_ram_resp_pipe #(.READ_LATENCY(READ_LATENCY), .resp_t(resp_t)) u_a_pipe (
        .clk(clk), .rst(rst), .in_vld(a_acc), .in_resp(a_in), .out_vld(a_rvalid), .out_resp(a_out)
    );

    bytewrite_ram_resp_pipe #(.READ_LATENCY(READ_LATENCY), .resp_t(resp_t)) u_b_pipe (
        .clk(clk), .rst(rst), .in_vld(b_acc), .in_resp(b_in), .out_vld(b_rvalid), .out_resp(b_out)
    );

    assign a_err   = a_rvalid && a_out.err;
    assign b_err   = b_rvalid && b_out.err;
    assign a_rdata = a_out.data;
    assign b_rdata = b_out.data;
endmodule

// File: tb/tb_bytewrite_ram_2p.sv
// Bench for bytewrite_ram_2p: directed vector table, corner sequences, random traffic vs a word-array model.
module tb_bytewrite_ram_2p;
    localparam int          LAT  = 3;
    localparam int          SIZE = 1024;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk = 1'b0, rst = 1'b1;
    logic        a_req = 1'b0, a_gnt, a_rvalid, a_err;
    logic [31:0] a_addr = '0, a_rdata;
    logic        b_req = 1'b0, b_gnt, b_rvalid, b_err;
    logic [3:0]  b_we = '0;
    logic [31:0] b_addr = '0, b_wdata = '0, b_rdata;

    always #5 clk = ~clk;

    bytewrite_ram_2p #(
        .SIZE(SIZE), .ADDR_WIDTH(32), .COL_WIDTH(8), .NB_COL(4),
        .READ_LATENCY(LAT), .BASE_ADDR(BASE), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err)
    );

    int checks = 0, errors = 0, cyc = 0;
    int pulses [2];
    int reqc = 0, lowc = 0;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
        logic [3:0]  known;
    } exp_t;

    exp_t        q [2][$];
    logic [31:0] ref_mem   [SIZE];
    logic [3:0]  ref_known [SIZE];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    function automatic bit is_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < BASE) || (((addr - BASE) >> 2) >= 32'(SIZE));
    endfunction

    function automatic logic [31:0] cmask(input logic [3:0] k);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    // Reference: word array with per-byte "known" flags, response queue per port.
    task automatic model(input int p, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int   idx;
        e.due = cyc + LAT;
        if (is_bad(addr)) begin
            e.err = 1'b1; e.data = '0; e.known = 4'hF;
        end else begin
            idx     = int'((addr - BASE) >> 2);
            e.err   = 1'b0;
            e.data  = ref_mem[idx];
            e.known = ref_known[idx];
            if (p == 1) begin
                for (int i = 0; i < 4; i++) begin
                    if (we[i]) begin
                        ref_mem[idx][i*8 +: 8] = wd[i*8 +: 8];
                        ref_known[idx][i]      = 1'b1;
                    end
                end
            end
        end
        q[p].push_back(e);
    endtask

    task automatic mon(input int p, input logic v, input logic er, input logic [31:0] d);
        exp_t e;
        if (v === 1'b1) begin
            pulses[p]++;
            if (q[p].size() == 0) begin
                fail($sformatf("p%0d_spurious_rvalid", p));
            end else begin
                e = q[p].pop_front();
                check($sformatf("p%0d_resp_cycle", p), cyc, e.due);
                check($sformatf("p%0d_err", p), {31'b0, er}, {31'b0, e.err});
                check($sformatf("p%0d_rdata", p), d & cmask(e.known), e.data & cmask(e.known));
            end
        end else if (q[p].size() > 0 && q[p][0].due <= cyc) begin
            fail($sformatf("p%0d_missing_rvalid due %0d", p, q[p][0].due));
            void'(q[p].pop_front());
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_rvalid, a_err, a_rdata);
        mon(1, b_rvalid, b_err, b_rdata);
        if (!rst && a_req) begin
            reqc++;
            if (!a_gnt) lowc++;
        end
    end

    // Present requests, holding each until granted; model A before B so a collision reads old data.
    task automatic issue(input logic ar, input logic [31:0] aa,
                         input logic br, input logic [3:0] bw, input logic [31:0] ba, input logic [31:0] bd);
        bit pa, pb;
        int n;
        pa = ar; pb = br; n = 0;
        a_addr = aa; b_we = bw; b_addr = ba; b_wdata = bd;
        while ((pa || pb) && n < 100) begin
            a_req = pa; b_req = pb;
            @(negedge clk);
            if (pa && a_gnt) begin model(0, 4'h0, aa, 32'h0); pa = 0; end
            if (pb && b_gnt) begin model(1, bw, ba, bd); pb = 0; end
            @(posedge clk); #1;
            n++;
        end
        a_req = 1'b0; b_req = 1'b0;
        if (pa || pb) fail("gnt_timeout");
    endtask

    task automatic wait_resp(input int p, output logic [31:0] d, output logic er, output int lat);
        bit got;
        got = 0; lat = -1; d = '0; er = 1'b0;
        for (int k = 1; k <= LAT + 20 && !got; k++) begin
            @(negedge clk);
            if ((p == 0) ? a_rvalid : b_rvalid) begin
                got = 1; lat = k;
                d  = (p == 0) ? a_rdata : b_rdata;
                er = (p == 0) ? a_err : b_err;
            end
            @(posedge clk); #1;
        end
        if (!got) fail($sformatf("p%0d_resp_timeout", p));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("a_gnt_in_reset", {31'b0, a_gnt}, 32'h0);
            check("b_gnt_in_reset", {31'b0, b_gnt}, 32'h0);
            @(posedge clk); #1;
            if (i == 0) begin q[0].delete(); q[1].delete(); end
        end
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    typedef struct {
        int          p;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        experr;
        bit          chk;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 32'(4 * $urandom_range(0, 31) + $urandom_range(1, 3));
        if (r == 1) return 32'(4 * SIZE + 4 * $urandom_range(0, 15));
        return 32'(4 * $urandom_range(0, 31));
    endfunction

    initial begin
        logic [31:0] d;
        logic        er;
        int          lat, p0, l0, r0;

        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        er;
        int          lat, p0, l0, r0;

        for (int i = 0; i < SIZE; i++) begin ref_mem[i] = '0; ref_known[i] = 4'h0; end
        pulses[0] = 0; pulses[1] = 0;

        tbl[0]  = '{1, 4'hF, 32'h00, 32'hA5A50001, 32'h0,        1'b0, 1'b0};
        tbl[1]  = '{0, 4'h0, 32'h00, 32'h0,        32'hA5A50001, 1'b0, 1'b1};
        tbl[2]  = '{1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        tbl[3]  = '{1, 4'h2, 32'h10, 32'h00005500, 32'hDEADBEEF, 1'b0, 1'b1};
        tbl[4]  = '{1, 4'h0, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0, 1'b1};
        tbl[5]  = '{1, 4'h0, 32'h13, 32'h0,        32'h0,        1'b1, 1'b1};
        tbl[6]  = '{0, 4'h0, BASE + 32'(4 * SIZE), 32'h0, 32'h0, 1'b1, 1'b1};
        tbl[7]  = '{1, 4'hF, 32'h13, 32'h00000000, 32'h0,        1'b1, 1'b1};
        tbl[8]  = '{0, 4'h0, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0, 1'b1};
        tbl[9]  = '{1, 4'hF, 32'h20, 32'h11111111, 32'h0,        1'b0, 1'b0};
        tbl[10] = '{1, 4'h0, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0, 1'b1};

        // Reset: 3 cycles held, then all response outputs idle at zero.
        @(posedge clk); #1;
        do_reset(3);
        @(negedge clk);
        check("a_rvalid_rst", {31'b0, a_rvalid}, 32'h0);
        check("a_err_rst",    {31'b0, a_err},    32'h0);
        check("a_rdata_rst",  a_rdata,           32'h0);
        check("b_rvalid_rst", {31'b0, b_rvalid}, 32'h0);
        check("b_err_rst",    {31'b0, b_err},    32'h0);
        check("b_rdata_rst",  b_rdata,           32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            issue(tbl[i].p == 0, tbl[i].addr, tbl[i].p == 1, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            wait_resp(tbl[i].p, d, er, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
            if (tbl[i].chk) begin
                check($sformatf("vec%0d_rdata", i), d, tbl[i].exp);
                check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, tbl[i].experr});
            end
        end

        // Collision on 0x20: A sees the old word, the following A read sees B's write.
        issue(1'b1, 32'h20, 1'b1, 4'hF, 32'h20, 32'h12345678);
        wait_resp(0, d, er, lat);
`ifndef BYTEWRITE_RAM_STALL_EN
        check("collision_a_old", d, 32'h11111111);
`endif
        idle(LAT + 2);
        issue(1'b1, 32'h20, 1'b0, 4'h0, 32'h0, 32'h0);
        wait_resp(0, d, er, lat);
        check("collision_a_new", d, 32'h12345678);

        // Back-to-back burst of 8 reads, all answered in order.
        p0 = pulses[0];
        for (int i = 0; i < 8; i++) issue(1'b1, 32'(4 * i), 1'b0, 4'h0, 32'h0, 32'h0);
        idle(LAT + 2);
        check("burst_pulses", 32'(pulses[0] - p0), 32'd8);

        // Reset mid-burst: in-flight responses are dropped, memory survives.
        for (int i = 0; i < 4; i++) issue(1'b1, 32'(4 * i), 1'b0, 4'h0, 32'h0, 32'h0);
        do_reset(2);
        p0 = pulses[0];
        idle(10);
        check("no_rvalid_after_reset", 32'(pulses[0] - p0), 32'd0);
        issue(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 32'h0);
        wait_resp(0, d, er, lat);
        check("mem_kept_over_reset", d, 32'hDEAD55EF);

        // Random two-port traffic against the model.
        l0 = lowc; r0 = reqc;
        for (int i = 0; i < 300; i++) begin
            issue($urandom_range(0, 1) == 1, rand_addr(),
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0,
                  rand_addr(), $urandom());
        end
        idle(LAT + 2);
        check("rand_a_drained", 32'(q[0].size()), 32'd0);
        check("rand_b_drained", 32'(q[1].size()), 32'd0);
`ifndef BYTEWRITE_RAM_STALL_EN
        check("no_stalls_default", 32'(lowc - l0), 32'd0);
`endif

`ifdef BYTEWRITE_RAM_STALL_EN
        // 1000-request stream on both ports; grant-low fraction near 25%.
        l0 = lowc; r0 = reqc;
        for (int i = 0; i < 1000; i++) issue(1'b1, rand_addr(), 1'b1, 4'h0, rand_addr(), 32'h0);
        idle(LAT + 2);
        check("stall_a_drained", 32'(q[0].size()), 32'd0);
        check("stall_b_drained", 32'(q[1].size()), 32'd0);
        if ((lowc - l0) * 100 < 20 * (reqc - r0) || (lowc - l0) * 100 > 30 * (reqc - r0))
            fail($sformatf("stall_fraction low=%0d of %0d", lowc - l0, reqc - r0));
        else
            checks++;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
